mem_seq: RTL and testbench

//  Cache-side sequencer directly upstream of the 256b main memory model. Accepts one line

---
 rtl/mem_seq.sv | 235 +++++++++++++++++++++++
 tb/tb_mem_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_seq.sv
// mem_seq: line-request sequencer in front of the main memory model.
// Runs a writeback, a fill, or a writeback followed by a fill. It issues
// single-cycle read/write pulses and holds the memory address and data until
// memory responds.
// Optional feature macro: MEMSEQ_TIMEOUT_EN adds a wait-state timeout that
// aborts the request with an err pulse.
module mem_seq #(
   parameter int unsigned ADDR_W      = 27,
   parameter int unsigned DATA_W      = 256,
   parameter int unsigned MEM_ENTRIES = 256,
   parameter int unsigned TIMEOUT     = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wb,
   input  logic                  req_fill,
   input  logic [ADDR_W-1:0]     req_wb_addr,
   input  logic [ADDR_W-1:0]     req_fill_addr,
   input  logic [DATA_W-1:0]     req_wb_data,
   output logic                  fill_valid,
   output logic [DATA_W-1:0]     fill_data,
   output logic [ADDR_W-1:0]     fill_addr,
   output logic                  wb_done,
   output logic                  err,
   output logic [ADDR_W-1:0]     mem_a,
   output logic [DATA_W/8-1:0]   mem_be,
   output logic [DATA_W-1:0]     mem_wd,
   output logic                  mem_write,
   output logic                  mem_read,
   input  logic [DATA_W-1:0]     mem_rd,
   input  logic                  mem_valid,
   input  logic                  mem_ready
);

   localparam int unsigned BE_W  = DATA_W / 8;
   localparam int unsigned CNT_W = 4;

   // Elaboration-time sanity checks on the configuration.
   if (TIMEOUT < 1 || TIMEOUT > (1 << CNT_W)) begin : g_bad_timeout
      $error("mem_seq: TIMEOUT must be in 1..16");
   end
   if ((DATA_W % 8) != 0) begin : g_bad_data_w
      $error("mem_seq: DATA_W must be a multiple of 8");
   end

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WB_ISSUE = 3'd1,
      S_WB_WAIT  = 3'd2,
      S_RD_ISSUE = 3'd3,
      S_RD_WAIT  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic                req_ready_q, req_ready_d;
   logic                do_fill_q, do_fill_d;
   logic [ADDR_W-1:0]   rq_fill_addr_q, rq_fill_addr_d;
   logic                fill_valid_q, fill_valid_d;
   logic [DATA_W-1:0]   fill_data_q, fill_data_d;
   logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
   logic                wb_done_q, wb_done_d;
   logic                err_q, err_d;
   logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
   logic [BE_W-1:0]     mem_be_q, mem_be_d;
   logic [DATA_W-1:0]   mem_wd_q, mem_wd_d;
   logic                mem_write_q, mem_write_d;
   logic                mem_read_q, mem_read_d;
   logic                addr_bad_c;

`ifdef MEMSEQ_TIMEOUT_EN
   logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
   logic                wait_expired_c;
   assign wait_expired_c = (wait_cnt_q == CNT_W'(TIMEOUT - 1));
`endif

   // Range check on whichever addresses the incoming request actually uses.
   assign addr_bad_c = (req_wb   && (req_wb_addr   >= ADDR_W'(MEM_ENTRIES))) ||
                       (req_fill && (req_fill_addr >= ADDR_W'(MEM_ENTRIES)));

   // Next-state, request latching and registered-output computation.
   always_comb begin
      state_d        = state_q;
      do_fill_d      = do_fill_q;
      rq_fill_addr_d = rq_fill_addr_q;
      fill_data_d    = fill_data_q;
      fill_addr_d    = fill_addr_q;
      mem_a_d        = mem_a_q;
      mem_be_d       = mem_be_q;
      mem_wd_d       = mem_wd_q;
      fill_valid_d   = 1'b0;
      wb_done_d      = 1'b0;
      err_d          = 1'b0;
      mem_write_d    = 1'b0;
      mem_read_d     = 1'b0;
`ifdef MEMSEQ_TIMEOUT_EN
      wait_cnt_d     = wait_cnt_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               do_fill_d      = req_fill;
               rq_fill_addr_d = req_fill_addr;
               if ((!req_wb && !req_fill) || addr_bad_c) begin
                  err_d = 1'b1;
               end else if (req_wb) begin
                  state_d     = S_WB_ISSUE;
                  mem_write_d = 1'b1;
                  mem_a_d     = req_wb_addr;
                  mem_wd_d    = req_wb_data;
                  mem_be_d    = {BE_W{1'b1}};
               end else begin
                  state_d    = S_RD_ISSUE;
                  mem_read_d = 1'b1;
                  mem_a_d    = req_fill_addr;
                  mem_be_d   = '0;
               end
            end
         end

         S_WB_ISSUE: begin
            state_d = S_WB_WAIT;
`ifdef MEMSEQ_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
         end

         S_WB_WAIT: begin
            if (mem_ready) begin
               if (do_fill_q) begin
                  state_d    = S_RD_ISSUE;
                  mem_read_d = 1'b1;
                  mem_a_d    = rq_fill_addr_q;
                  mem_be_d   = '0;
               end else begin
                  state_d   = S_IDLE;
                  wb_done_d = 1'b1;
               end
            end
`ifdef MEMSEQ_TIMEOUT_EN
            else if (wait_expired_c) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
`endif
         end

         S_RD_ISSUE: begin
            state_d = S_RD_WAIT;
`ifdef MEMSEQ_TIMEOUT_EN
            wait_cnt_d = '0;
`endif
         end

         S_RD_WAIT: begin
            if (mem_valid) begin
               state_d      = S_IDLE;
               fill_valid_d = 1'b1;
               fill_data_d  = mem_rd;
               fill_addr_d  = rq_fill_addr_q;
            end
`ifdef MEMSEQ_TIMEOUT_EN
            else if (wait_expired_c) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
`endif
         end

         default: state_d = S_IDLE;
      endcase

      req_ready_d = (state_d == S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         req_ready_q    <= 1'b0;
         do_fill_q      <= 1'b0;
         rq_fill_addr_q <= '0;
         fill_valid_q   <= 1'b0;
         fill_data_q    <= '0;
         fill_addr_q    <= '0;
         wb_done_q      <= 1'b0;
         err_q          <= 1'b0;
         mem_a_q        <= '0;
         mem_be_q       <= '0;
         mem_wd_q       <= '0;
         mem_write_q    <= 1'b0;
         mem_read_q     <= 1'b0;
`ifdef MEMSEQ_TIMEOUT_EN
         wait_cnt_q     <= '0;
`endif
      end else begin
         state_q        <= state_d;
         req_ready_q    <= req_ready_d;
         do_fill_q      <= do_fill_d;
         rq_fill_addr_q <= rq_fill_addr_d;
         fill_valid_q   <= fill_valid_d;
         fill_data_q    <= fill_data_d;
         fill_addr_q    <= fill_addr_d;
         wb_done_q      <= wb_done_d;
         err_q          <= err_d;
         mem_a_q        <= mem_a_d;
         mem_be_q       <= mem_be_d;
         mem_wd_q       <= mem_wd_d;
         mem_write_q    <= mem_write_d;
         mem_read_q     <= mem_read_d;
`ifdef MEMSEQ_TIMEOUT_EN
         wait_cnt_q     <= wait_cnt_d;
`endif
      end
   end

   assign req_ready  = req_ready_q;
   assign fill_valid = fill_valid_q;
   assign fill_data  = fill_data_q;
   assign fill_addr  = fill_addr_q;
   assign wb_done    = wb_done_q;
   assign err        = err_q;
   assign mem_a      = mem_a_q;
   assign mem_be     = mem_be_q;
   assign mem_wd     = mem_wd_q;
   assign mem_write  = mem_write_q;
   assign mem_read   = mem_read_q;

endmodule

// File: tb/tb_mem_seq.sv
// Scoreboard bench for mem_seq against a 2-cycle memory model.
module tb_mem_seq;

   localparam int unsigned AW = 27;
   localparam int unsigned DW = 256;
   localparam int unsigned BW = DW / 8;

   localparam int K_FILL = 0;
   localparam int K_WB   = 1;
   localparam int K_ERR  = 2;
   localparam int K_RD   = 3;
   localparam int K_WR   = 4;

   logic          clk, rst;
   logic          req_valid, req_ready, req_wb, req_fill;
   logic [AW-1:0] req_wb_addr, req_fill_addr;
   logic [DW-1:0] req_wb_data;
   logic          fill_valid, wb_done, err;
   logic [DW-1:0] fill_data;
   logic [AW-1:0] fill_addr;
   logic [AW-1:0] mem_a;
   logic [BW-1:0] mem_be;
   logic [DW-1:0] mem_wd, mem_rd;
   logic          mem_write, mem_read, mem_valid, mem_ready;

   mem_seq dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_wb(req_wb), .req_fill(req_fill),
      .req_wb_addr(req_wb_addr), .req_fill_addr(req_fill_addr),
      .req_wb_data(req_wb_data),
      .fill_valid(fill_valid), .fill_data(fill_data), .fill_addr(fill_addr),
      .wb_done(wb_done), .err(err),
      .mem_a(mem_a), .mem_be(mem_be), .mem_wd(mem_wd),
      .mem_write(mem_write), .mem_read(mem_read),
      .mem_rd(mem_rd), .mem_valid(mem_valid), .mem_ready(mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: responds two cycles after each pulse unless muted.
   logic [DW-1:0] ram [0:255];
   logic          rp0 = 1'b0, rp1 = 1'b0, wp0 = 1'b0, wp1 = 1'b0;
   logic [7:0]    rd_addr = 8'd0;
   logic          mute = 1'b0;
   logic          saw_late = 1'b0;

   always @(posedge clk) begin
      rp0 <= (mem_read === 1'b1) && !mute;
      rp1 <= rp0;
      wp0 <= (mem_write === 1'b1) && !mute;
      wp1 <= wp0;
      if (mem_read === 1'b1) rd_addr <= mem_a[7:0];
      if (mem_write === 1'b1) ram[mem_a[7:0]] <= mem_wd;
   end
   assign mem_valid = rp1;
   assign mem_ready = wp1;
   assign mem_rd    = ram[rd_addr];

   typedef struct {
      int            kind;
      int            cyc;
      logic [DW-1:0] data;
      logic [AW-1:0] addr;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   logic mon_en = 1'b0;

   task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   task automatic push(input int kind, input int c, input logic [DW-1:0] d, input logic [AW-1:0] a);
      exp_t e;
      e.kind = kind; e.cyc = c; e.data = d; e.addr = a;
      q.push_back(e);
   endtask

   task automatic pop_cmp(input int kind);
      exp_t e;
      if (q.size() == 0) begin
         check($sformatf("unexpected_event_kind%0d", kind), DW'(1), DW'(0));
         return;
      end
      e = q.pop_front();
      check("event_kind", DW'(kind), DW'(e.kind));
      check("event_cycle", DW'(cyc), DW'(e.cyc));
      case (kind)
         K_FILL: begin
            check("fill_data", fill_data, e.data);
            check("fill_addr", DW'(fill_addr), DW'(e.addr));
         end
         K_RD: begin
            check("rd_mem_a", DW'(mem_a), DW'(e.addr));
            check("rd_mem_be", DW'(mem_be), DW'(0));
         end
         K_WR: begin
            check("wr_mem_a", DW'(mem_a), DW'(e.addr));
            check("wr_mem_wd", mem_wd, e.data);
            check("wr_mem_be", DW'(mem_be), DW'({BW{1'b1}}));
         end
         default: ;
      endcase
   endtask

   // Monitor: every output pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         if (fill_valid === 1'b1) pop_cmp(K_FILL);
         if (wb_done === 1'b1)    pop_cmp(K_WB);
         if (err === 1'b1)        pop_cmp(K_ERR);
         if (mem_read === 1'b1)   pop_cmp(K_RD);
         if (mem_write === 1'b1)  pop_cmp(K_WR);
      end
   end

   // Drive a request at the next cycle where req_ready is high; t = accept cycle.
   task automatic start_req(input logic wb, input logic fill, input logic [AW-1:0] wba,
                            input logic [AW-1:0] fa, input logic [DW-1:0] wd, output int t);
      int n = 0;
      @(negedge clk);
      while (req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("req_ready_wait_timeout", DW'(0), DW'(1));
      req_valid = 1'b1; req_wb = wb; req_fill = fill;
      req_wb_addr = wba; req_fill_addr = fa; req_wb_data = wd;
      t = cyc;
   endtask

   task automatic end_req();
      @(negedge clk);
      req_valid = 1'b0; req_wb = 1'b0; req_fill = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("drain_timeout", DW'(q.size()), DW'(0));
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      logic [DW-1:0] a5;
      a5 = {32{8'hA5}};
      for (int i = 0; i < 256; i++) ram[i] = '0;
      ram[5] = a5;
      rst = 1'b1; req_valid = 1'b0; req_wb = 1'b0; req_fill = 1'b0;
      req_wb_addr = '0; req_fill_addr = '0; req_wb_data = '0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_req_ready", DW'(req_ready), DW'(0));
      check("rst_fill_valid", DW'(fill_valid), DW'(0));
      check("rst_wb_done", DW'(wb_done), DW'(0));
      check("rst_err", DW'(err), DW'(0));
      check("rst_mem_read", DW'(mem_read), DW'(0));
      check("rst_mem_write", DW'(mem_write), DW'(0));
      check("rst_mem_a", DW'(mem_a), DW'(0));
      check("rst_mem_be", DW'(mem_be), DW'(0));
      check("rst_mem_wd", mem_wd, DW'(0));
      check("rst_fill_data", fill_data, DW'(0));
      check("rst_fill_addr", DW'(fill_addr), DW'(0));
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_req_ready", DW'(req_ready), DW'(1));
      mon_en = 1'b1;

      // Fill-only
      start_req(1'b0, 1'b1, AW'(0), AW'(5), DW'(0), t);
      push(K_RD, t + 1, DW'(0), AW'(5));
      push(K_FILL, t + 4, a5, AW'(5));
      end_req();
      drain();

      // Writeback-only
      start_req(1'b1, 1'b0, AW'(3), AW'(0), DW'(32'h1234), t);
      push(K_WR, t + 1, DW'(32'h1234), AW'(3));
      push(K_WB, t + 4, DW'(0), AW'(0));
      end_req();
      drain();
      check("ram3_written", ram[3], DW'(32'h1234));

      // Writeback then fill of the same line
      start_req(1'b1, 1'b1, AW'(7), AW'(7), DW'(32'hBEEF), t);
      push(K_WR, t + 1, DW'(32'hBEEF), AW'(7));
      push(K_RD, t + 4, DW'(0), AW'(7));
      push(K_FILL, t + 7, DW'(32'hBEEF), AW'(7));
      end_req();
      drain();

      // Fill address just past the end
      start_req(1'b0, 1'b1, AW'(0), AW'(256), DW'(0), t);
      push(K_ERR, t + 1, DW'(0), AW'(0));
      end_req();
      check("range_req_ready_back", DW'(req_ready), DW'(1));
      drain();

      // Bad writeback address combined with a good fill
      start_req(1'b1, 1'b1, AW'(300), AW'(5), DW'(1), t);
      push(K_ERR, t + 1, DW'(0), AW'(0));
      end_req();
      drain();

      // Empty request
      start_req(1'b0, 1'b0, AW'(1), AW'(1), DW'(0), t);
      push(K_ERR, t + 1, DW'(0), AW'(0));
      end_req();
      check("noop_req_ready", DW'(req_ready), DW'(1));
      drain();

      // Reset while waiting for read data; late mem_valid must be dropped
      start_req(1'b0, 1'b1, AW'(0), AW'(5), DW'(0), t);
      push(K_RD, t + 1, DW'(0), AW'(5));
      end_req();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      saw_late = (mem_valid === 1'b1);
      @(negedge clk);
      check("mid_rst_req_ready", DW'(req_ready), DW'(1));
      check("mid_rst_late_resp_seen", DW'(saw_late), DW'(1));
      repeat (8) @(negedge clk);
      check("mid_rst_queue_empty", DW'(q.size()), DW'(0));

      // Recovery: read back the line written earlier
      start_req(1'b0, 1'b1, AW'(0), AW'(3), DW'(0), t);
      push(K_RD, t + 1, DW'(0), AW'(3));
      push(K_FILL, t + 4, DW'(32'h1234), AW'(3));
      end_req();
      drain();

`ifdef MEMSEQ_TIMEOUT_EN
      // Memory never responds: abort after 15 wait cycles
      mute = 1'b1;
      start_req(1'b0, 1'b1, AW'(0), AW'(9), DW'(0), t);
      push(K_RD, t + 1, DW'(0), AW'(9));
      push(K_ERR, t + 17, DW'(0), AW'(0));
      end_req();
      while (cyc < t + 17) @(negedge clk);
      check("timeout_req_ready", DW'(req_ready), DW'(1));
      drain();
      mute = 1'b0;
`endif

      check("final_queue_empty", DW'(q.size()), DW'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
